data_mem_responder: RTL and testbench

Memory-side responder for the multi-channel data memory interface driven by `mem_controller`. It terminates the `data_mem_*` channels of the GPU top and owns a word-addressed storage array. Each channel has an independent per-request FSM with fixed, parameterised read and write latencies. It serves as the synthesizable on-chip data memory and as the bench memory model.

---
 rtl/data_mem_responder_pkg.sv | 23 ++
 rtl/data_mem_responder_if.sv | 32 +++
 rtl/data_mem_responder_channel.sv | 83 ++++++++
 rtl/data_mem_responder.sv | 100 ++++++++++
 tb/tb_data_mem_responder.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-memory responder and its sibling responders.
// Holds the word/address types and the per-request responder FSM state enum.
package data_mem_responder_pkg;

  localparam int DMEM_DATA_W = 16;
  localparam int DMEM_ADDR_W = 12;

  typedef logic [DMEM_DATA_W-1:0] data_t;
  typedef logic [DMEM_ADDR_W-1:0] data_memory_address_t;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_R,
    BUSY_W,
    RESPOND,
    RELEASE
  } mem_resp_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Multi-channel data-memory request/response bus between mem_controller
// (master) and the memory-side responder (slave).
interface data_mem_responder_if
  import data_mem_responder_pkg::*;
#(
  parameter int NUM_CHANNELS  = 8,
  parameter int DATA_WIDTH    = DMEM_DATA_W,
  parameter int ADDRESS_WIDTH = DMEM_ADDR_W
);

  logic [NUM_CHANNELS-1:0]                    mem_read_valid;
  logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0] mem_read_address;
  logic [NUM_CHANNELS-1:0]                    mem_read_ready;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]    mem_read_data;
  logic [NUM_CHANNELS-1:0]                    mem_write_valid;
  logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0] mem_write_address;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]    mem_write_data;
  logic [NUM_CHANNELS-1:0]                    mem_write_ready;

  modport master (
    output mem_read_valid, mem_read_address,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready
  );

  modport slave (
    input  mem_read_valid, mem_read_address,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready
  );

endinterface

// File: rtl/data_mem_responder_channel.sv
// mem_responder_channel: one channel's request FSM and latency counter.
// The array lives in the parent; this block only decides when to capture/commit.
module mem_responder_channel
  import data_mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH    = DMEM_DATA_W,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read_valid,
  input  logic                  write_valid,
  input  logic [DATA_WIDTH-1:0] rd_word,
  output logic                  rd_capture,
  output logic                  wr_commit,
  output logic                  read_ready,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  write_ready
);

  localparam int CNT_W = $clog2(max_int(READ_LATENCY, WRITE_LATENCY) + 1);

  mem_resp_state_t       state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  is_wr_q, is_wr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      is_wr_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_wr_d    = is_wr_q;
    rdata_d    = rdata_q;
    rd_capture = 1'b0;
    wr_commit  = 1'b0;
    case (state_q)
      IDLE: begin
        // Write wins over a simultaneous read on the same channel.
        if (write_valid) begin
          wr_commit = 1'b1;
          is_wr_d   = 1'b1;
          cnt_d     = CNT_W'(WRITE_LATENCY);
          state_d   = BUSY_W;
        end else if (read_valid) begin
          rd_capture = 1'b1;
          is_wr_d    = 1'b0;
          rdata_d    = rd_word;
          cnt_d      = CNT_W'(READ_LATENCY);
          state_d    = BUSY_R;
        end
      end
      BUSY_R, BUSY_W: begin
        if (cnt_q == CNT_W'(1)) state_d = RESPOND;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      RESPOND: state_d = RELEASE;
      RELEASE: begin
        // A request still held after its response must not be served twice.
        if (is_wr_q ? !write_valid : !read_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign read_ready  = (state_q == RESPOND) && !is_wr_q;
  assign write_ready = (state_q == RESPOND) &&  is_wr_q;
  assign read_data   = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the multi-channel data memory: owns the word array,
// write priority and preload port. Optional macro: DATA_MEM_RANGE_CHECK_EN.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int NUM_CHANNELS  = 8,
  parameter int DATA_WIDTH    = DMEM_DATA_W,
  parameter int ADDRESS_WIDTH = DMEM_ADDR_W,
  parameter int DEPTH         = 256,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  data_mem_responder_if.slave      bus,
  input  logic                     load_valid,
  input  logic [ADDRESS_WIDTH-1:0] load_address,
  input  logic [DATA_WIDTH-1:0]    load_data,
  output logic                     addr_error
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0]                   mem_q [DEPTH];
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] rd_word;
  logic [NUM_CHANNELS-1:0]                 rd_capture;
  logic [NUM_CHANNELS-1:0]                 wr_commit;
  logic [NUM_CHANNELS-1:0]                 rd_ok;
  logic [NUM_CHANNELS-1:0]                 wr_ok;
  logic                                    load_ok;

  // Reads see the array as it was before this edge's writes.
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      rd_word[c] = rd_ok[c] ? mem_q[bus.mem_read_address[c][IDX_W-1:0]] : '0;
    end
  end

  // Later assignments win: higher channel index, then the preload port.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (wr_commit[c] && wr_ok[c]) begin
        mem_q[bus.mem_write_address[c][IDX_W-1:0]] <= bus.mem_write_data[c];
      end
    end
    if (load_valid && load_ok) begin
      mem_q[load_address[IDX_W-1:0]] <= load_data;
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
    mem_responder_channel #(
      .DATA_WIDTH   (DATA_WIDTH),
      .READ_LATENCY (READ_LATENCY),
      .WRITE_LATENCY(WRITE_LATENCY)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .read_valid (bus.mem_read_valid[g]),
      .write_valid(bus.mem_write_valid[g]),
      .rd_word    (rd_word[g]),
      .rd_capture (rd_capture[g]),
      .wr_commit  (wr_commit[g]),
      .read_ready (bus.mem_read_ready[g]),
      .read_data  (bus.mem_read_data[g]),
      .write_ready(bus.mem_write_ready[g])
    );
  end

`ifdef DATA_MEM_RANGE_CHECK_EN
  localparam logic [ADDRESS_WIDTH:0] DEPTH_A = (ADDRESS_WIDTH + 1)'(DEPTH);

  logic addr_error_q, addr_error_d;

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      rd_ok[c] = {1'b0, bus.mem_read_address[c]}  < DEPTH_A;
      wr_ok[c] = {1'b0, bus.mem_write_address[c]} < DEPTH_A;
    end
    load_ok      = {1'b0, load_address} < DEPTH_A;
    addr_error_d = addr_error_q | (|(rd_capture & ~rd_ok)) | (|(wr_commit & ~wr_ok));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) addr_error_q <= 1'b0;
    else        addr_error_q <= addr_error_d;
  end

  assign addr_error = addr_error_q;
`else
  logic unused_bits;

  assign rd_ok       = '1;
  assign wr_ok       = '1;
  assign load_ok     = 1'b1;
  assign addr_error  = 1'b0;
  assign unused_bits = ^{rd_capture, bus.mem_read_address, bus.mem_write_address, load_address};
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: table of preload/write/read vectors
// plus hand-written sequences for priority, hold, reset and range corner cases.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  localparam int NCH = 8;
  localparam int DW  = DMEM_DATA_W;
  localparam int AW  = DMEM_ADDR_W;
  localparam int RL  = 2;
  localparam int WL  = 1;
  localparam int OP_LOAD = 0, OP_WRITE = 1, OP_READ = 2;

  typedef struct {
    int    op;
    int    ch;
    int    addr;
    data_t data;
  } vec_t;

  logic  clk = 1'b0;
  logic  reset;
  logic  load_valid;
  data_memory_address_t load_address;
  data_t load_data;
  logic  addr_error;
  int    errors = 0;
  int    checks = 0;

  data_mem_responder_if #(.NUM_CHANNELS(NCH), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  data_mem_responder #(
    .NUM_CHANNELS(NCH), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
    .DEPTH(256), .READ_LATENCY(RL), .WRITE_LATENCY(WL)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .load_valid(load_valid), .load_address(load_address), .load_data(load_data),
    .addr_error(addr_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges from request launch (capture edge = 1) to the ready strobe.
  task automatic wait_ready(input int ch, input bit is_wr, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(is_wr ? bus.mem_write_ready[ch] : bus.mem_read_ready[ch]) && n < 20);
  endtask

  task automatic preload(input int addr, input data_t d);
    load_valid   = 1'b1;
    load_address = AW'(addr);
    load_data    = d;
    tick();
    load_valid   = 1'b0;
  endtask

  task automatic do_read(input string name, input int ch, input int addr, input data_t exp);
    int n;
    bus.mem_read_address[ch] = AW'(addr);
    bus.mem_read_valid[ch]   = 1'b1;
    wait_ready(ch, 1'b0, n);
    check({name, " rd_lat"}, n, RL + 1);
    check({name, " rd_data"}, bus.mem_read_data[ch], exp);
    bus.mem_read_valid[ch] = 1'b0;
    tick();
    check({name, " rd_single"}, bus.mem_read_ready[ch], 1'b0);
    tick();
  endtask

  task automatic do_write(input string name, input int ch, input int addr, input data_t d);
    int n;
    bus.mem_write_address[ch] = AW'(addr);
    bus.mem_write_data[ch]    = d;
    bus.mem_write_valid[ch]   = 1'b1;
    wait_ready(ch, 1'b1, n);
    check({name, " wr_lat"}, n, WL + 1);
    bus.mem_write_valid[ch] = 1'b0;
    tick();
    check({name, " wr_single"}, bus.mem_write_ready[ch], 1'b0);
    tick();
  endtask

  initial begin
    vec_t vecs[10];
    int   n;
    logic any_ready;

    vecs[0] = '{OP_LOAD,  0,   5, 16'h1234};
    vecs[1] = '{OP_READ,  0,   5, 16'h1234};
    vecs[2] = '{OP_WRITE, 3,   9, 16'hBEEF};
    vecs[3] = '{OP_READ,  3,   9, 16'hBEEF};
    vecs[4] = '{OP_LOAD,  0,  44, 16'h00A5};
    vecs[5] = '{OP_READ,  7,  44, 16'h00A5};
    vecs[6] = '{OP_WRITE, 5, 100, 16'h5A5A};
    vecs[7] = '{OP_READ,  1, 100, 16'h5A5A};
    vecs[8] = '{OP_LOAD,  0, 255, 16'hFFFF};
    vecs[9] = '{OP_READ,  4, 255, 16'hFFFF};

    reset                 = 1'b0;
    load_valid            = 1'b0;
    load_address          = '0;
    load_data             = '0;
    bus.mem_read_valid    = '0;
    bus.mem_read_address  = '0;
    bus.mem_write_valid   = '0;
    bus.mem_write_address = '0;
    bus.mem_write_data    = '0;
    tick();
    tick();
    check("reset rd_ready", bus.mem_read_ready, '0);
    check("reset wr_ready", bus.mem_write_ready, '0);
    check("reset rd_data", bus.mem_read_data, '0);
    check("reset addr_error", addr_error, 1'b0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      case (vecs[i].op)
        OP_LOAD:  preload(vecs[i].addr, vecs[i].data);
        OP_WRITE: do_write($sformatf("vec%0d", i), vecs[i].ch, vecs[i].addr, vecs[i].data);
        default:  do_read($sformatf("vec%0d", i), vecs[i].ch, vecs[i].addr, vecs[i].data);
      endcase
    end

    // Same-edge writes to one address: highest channel wins.
    bus.mem_write_address[1] = AW'(7);
    bus.mem_write_data[1]    = 16'h0011;
    bus.mem_write_address[6] = AW'(7);
    bus.mem_write_data[6]    = 16'h0066;
    bus.mem_write_valid[1]   = 1'b1;
    bus.mem_write_valid[6]   = 1'b1;
    tick();
    tick();
    check("dual wr ready", bus.mem_write_ready, 8'b0100_0010);
    bus.mem_write_valid = '0;
    tick();
    tick();
    do_read("dual wr", 0, 7, 16'h0066);

    // Preload beats a same-edge channel write.
    bus.mem_write_address[6] = AW'(7);
    bus.mem_write_data[6]    = 16'h0099;
    bus.mem_write_valid[6]   = 1'b1;
    load_valid   = 1'b1;
    load_address = AW'(7);
    load_data    = 16'h0077;
    tick();
    load_valid = 1'b0;
    tick();
    check("load prio wr_ready", bus.mem_write_ready[6], 1'b1);
    bus.mem_write_valid[6] = 1'b0;
    tick();
    tick();
    do_read("load prio", 2, 7, 16'h0077);

    // Read captured at the same edge as another channel's write sees old data.
    bus.mem_read_address[0]  = AW'(9);
    bus.mem_read_valid[0]    = 1'b1;
    bus.mem_write_address[2] = AW'(9);
    bus.mem_write_data[2]    = 16'hCAFE;
    bus.mem_write_valid[2]   = 1'b1;
    tick();
    tick();
    check("rw race wr_ready", bus.mem_write_ready[2], 1'b1);
    check("rw race rd early", bus.mem_read_ready[0], 1'b0);
    bus.mem_write_valid[2] = 1'b0;
    tick();
    check("rw race rd_ready", bus.mem_read_ready[0], 1'b1);
    check("rw race old data", bus.mem_read_data[0], 16'hBEEF);
    bus.mem_read_valid[0] = 1'b0;
    tick();
    tick();
    do_read("rw race new", 5, 9, 16'hCAFE);

    // Held read_valid: no second response until valid is seen low.
    bus.mem_read_address[2] = AW'(5);
    bus.mem_read_valid[2]   = 1'b1;
    wait_ready(2, 1'b0, n);
    check("hold first lat", n, RL + 1);
    check("hold first data", bus.mem_read_data[2], 16'h1234);
    any_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      any_ready |= bus.mem_read_ready[2];
    end
    check("hold no repeat", any_ready, 1'b0);
    bus.mem_read_valid[2] = 1'b0;
    tick();
    bus.mem_read_valid[2] = 1'b1;
    wait_ready(2, 1'b0, n);
    check("hold second lat", n, RL + 1);
    bus.mem_read_valid[2] = 1'b0;
    tick();
    tick();

    // Reset during BUSY_R on every channel drops the requests.
    for (int c = 0; c < NCH; c++) bus.mem_read_address[c] = AW'(5);
    bus.mem_read_valid = '1;
    tick();
    reset = 1'b0;
    #1;
    check("mid reset rd_ready", bus.mem_read_ready, '0);
    check("mid reset rd_data", bus.mem_read_data, '0);
    tick();
    tick();
    check("held reset rd_ready", bus.mem_read_ready, '0);
    bus.mem_read_valid = '0;
    reset = 1'b1;
    any_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      any_ready |= |bus.mem_read_ready;
    end
    check("post reset no ready", any_ready, 1'b0);
    do_read("post reset data", 0, 5, 16'h1234);

    // Out-of-range address 300 (= 44 modulo 256).
`ifdef DATA_MEM_RANGE_CHECK_EN
    do_read("range rd", 0, 300, 16'h0000);
    check("range err set", addr_error, 1'b1);
    do_write("range wr", 3, 300, 16'hDEAD);
    do_read("range wr dropped", 1, 44, 16'h00A5);
    check("range err sticky", addr_error, 1'b1);
`else
    do_read("wrap rd", 0, 300, 16'h00A5);
    check("wrap err", addr_error, 1'b0);
    do_write("wrap wr", 3, 300, 16'hDEAD);
    do_read("wrap wr aliased", 1, 44, 16'hDEAD);
    check("wrap err still", addr_error, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
